// File: rtl/image_paste_pkg.sv
// Shared types and widths for the image_paste window-to-raster stage.
package image_paste_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  localparam int RGB_W   = 24;
  localparam int X_RES_W = 11;
  localparam int Y_RES_W = 11;
  localparam int CNT_W   = 12;

endpackage

// File: rtl/paste_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the oldest stored entry.
module paste_fifo
  import image_paste_pkg::*;
#(
  parameter int FIFO_AW = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [RGB_W-1:0] din,
  input  logic             pop,
  output logic [RGB_W-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [RGB_W-1:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[FIFO_AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: rtl/image_paste.sv
// Places a buffered window pixel stream back into a full raster at (start_x, start_y).
// Optional one-pixel border ring around the window: define IMAGE_PASTE_BORDER_EN.
//
// state | meaning
// IDLE  | waiting for first in_vs edge; input pixels ignored
// ARMED | FIFO collecting window pixels; waiting for output vsync
// RUN   | raster counters live; window pixels drawn from FIFO
module image_paste
  import image_paste_pkg::*;
#(
  parameter logic [11:0] H_DISP      = 12'd1920,
  parameter logic [11:0] V_DISP      = 12'd1080,
  parameter int          X_RES_WIDTH = 11,
  parameter int          Y_RES_WIDTH = 11,
`ifdef IMAGE_PASTE_BORDER_EN
  parameter logic [23:0] BORDER_RGB  = 24'hFF0000,
`endif
  parameter int          FIFO_AW     = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [X_RES_WIDTH-1:0] start_x,
  input  logic [Y_RES_WIDTH-1:0] start_y,
  input  logic [X_RES_WIDTH-1:0] end_x,
  input  logic [Y_RES_WIDTH-1:0] end_y,
  input  logic [RGB_W-1:0]       bg_rgb,
  input  logic                   in_vs,
  input  logic                   in_de,
  input  logic [RGB_W-1:0]       in_rgb,
  input  logic                   hs_i,
  input  logic                   vs_i,
  input  logic                   de_i,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   de_o,
  output logic [RGB_W-1:0]       rgb_o,
  output logic                   locked,
  output logic                   ovf,
  output logic                   unf
);

  state_t                 state;
  logic                   in_vs_d;
  logic                   vs_i_d;
  logic [CNT_W-1:0]       pixel_x;
  logic [CNT_W-1:0]       pixel_y;
  logic [X_RES_WIDTH-1:0] sx, ex;
  logic [Y_RES_WIDTH-1:0] sy, ey;

  logic             in_vs_rise, vs_rise, run;
  logic             fifo_clr, push, pop, win;
  logic             empty, full;
  logic [RGB_W-1:0] head;
  logic             border;

  assign in_vs_rise = in_vs & ~in_vs_d;
  assign vs_rise    = vs_i & ~vs_i_d;
  assign run        = (state == RUN);
  assign fifo_clr   = (state == IDLE) & in_vs_rise;
  assign push       = in_de & (state != IDLE);

  assign win = de_i & run &
               (CNT_W'(sx) <= pixel_x) & (pixel_x < CNT_W'(ex)) &
               (CNT_W'(sy) <= pixel_y) & (pixel_y < CNT_W'(ey));
  assign pop = win & ~empty;

`ifdef IMAGE_PASTE_BORDER_EN
  localparam int BW = CNT_W + 1;
  logic [BW-1:0] bx, by, bx1, by1;
  logic          col_ring, row_ring, col_span, row_span;

  // x+1 == sx stands in for x == sx-1 so a window at column/row 0 never wraps.
  assign bx  = BW'(pixel_x);
  assign by  = BW'(pixel_y);
  assign bx1 = bx + 1'b1;
  assign by1 = by + 1'b1;
  assign col_ring = (bx1 == BW'(sx)) | (bx == BW'(ex));
  assign row_ring = (by1 == BW'(sy)) | (by == BW'(ey));
  assign col_span = (bx1 >= BW'(sx)) & (bx <= BW'(ex));
  assign row_span = (by1 >= BW'(sy)) & (by <= BW'(ey));
  assign border   = de_i & run & ~win &
                    ((col_ring & row_span) | (row_ring & col_span));
`else
  assign border = 1'b0;
`endif

  paste_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fifo_clr),
    .push  (push),
    .din   (in_rgb),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      locked  <= 1'b0;
      in_vs_d <= 1'b0;
      vs_i_d  <= 1'b0;
    end else begin
      in_vs_d <= in_vs;
      vs_i_d  <= vs_i;
      case (state)
        IDLE:    if (in_vs_rise) state <= ARMED;
        ARMED:   if (vs_rise) begin
                   state  <= RUN;
                   locked <= 1'b1;
                 end
        RUN:     ;
        default: state <= IDLE;
      endcase
    end
  end

  // Shadowed window so mid-frame register writes land on the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx <= '0;
      ex <= '0;
      sy <= '0;
      ey <= '0;
    end else if (vs_rise) begin
      sx <= start_x;
      ex <= end_x;
      sy <= start_y;
      ey <= end_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (!run || vs_i) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (de_i) begin
      if (pixel_x == H_DISP - 12'd1) begin
        pixel_x <= '0;
        pixel_y <= (pixel_y == V_DISP - 12'd1) ? '0 : pixel_y + 1'b1;
      end else begin
        pixel_x <= pixel_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_o  <= 1'b0;
      vs_o  <= 1'b0;
      de_o  <= 1'b0;
      rgb_o <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      hs_o <= hs_i;
      vs_o <= vs_i;
      de_o <= de_i;
      if (!de_i)
        rgb_o <= '0;
      else if (win && !empty)
        rgb_o <= head;
`ifdef IMAGE_PASTE_BORDER_EN
      else if (border)
        rgb_o <= BORDER_RGB;
`endif
      else
        rgb_o <= bg_rgb;
      if (push && full && !pop) ovf <= 1'b1;
      if (win && empty)         unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_image_paste.sv
// Directed bench for image_paste on an 8x4 raster; a second instance has a 4-entry FIFO.
module tb_image_paste;

  localparam logic [23:0] BG     = 24'hABCDEF;
  localparam logic [23:0] BORDER = 24'hFF0000;
`ifdef IMAGE_PASTE_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] start_x, start_y, end_x, end_y;
  logic [23:0] bg_rgb, in_rgb;
  logic        in_vs, in_de, hs_i, vs_i, de_i;

  logic        hs_b, vs_b, de_b, locked_b, ovf_b, unf_b;
  logic [23:0] rgb_b;
  logic        hs_s, vs_s, de_s, locked_s, ovf_s, unf_s;
  logic [23:0] rgb_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  image_paste #(.H_DISP(12'd8), .V_DISP(12'd4), .FIFO_AW(3)) dut_big (
    .clk(clk), .rst_n(rst_n), .start_x(start_x), .start_y(start_y),
    .end_x(end_x), .end_y(end_y), .bg_rgb(bg_rgb), .in_vs(in_vs),
    .in_de(in_de), .in_rgb(in_rgb), .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i),
    .hs_o(hs_b), .vs_o(vs_b), .de_o(de_b), .rgb_o(rgb_b),
    .locked(locked_b), .ovf(ovf_b), .unf(unf_b)
  );

  image_paste #(.H_DISP(12'd8), .V_DISP(12'd4), .FIFO_AW(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start_x(start_x), .start_y(start_y),
    .end_x(end_x), .end_y(end_y), .bg_rgb(bg_rgb), .in_vs(in_vs),
    .in_de(in_de), .in_rgb(in_rgb), .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i),
    .hs_o(hs_s), .vs_o(vs_s), .de_o(de_s), .rgb_o(rgb_s),
    .locked(locked_s), .ovf(ovf_s), .unf(unf_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ring(int x, int y, int sx, int sy, int ex, int ey);
    return ((x == sx - 1 || x == ex) && y >= sy - 1 && y <= ey) ||
           ((y == sy - 1 || y == ey) && x >= sx - 1 && x <= ex);
  endfunction

  task automatic cyc(input logic vs, input logic hs, input logic de,
                     input logic [23:0] eb, input logic [23:0] es, input logic lk);
    vs_i = vs; hs_i = hs; de_i = de;
    tick();
    chk("rgb_big", rgb_b, eb);
    chk("rgb_small", rgb_s, es);
    chk("de_o", de_b, de);
    chk("vs_o", vs_b, vs);
    chk("hs_o", hs_b, hs);
    chk("locked", locked_b, lk);
    chk("de_o_small", de_s, de);
  endtask

  task automatic pushn(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_de = 1'b1; in_rgb = 24'(base + i);
      tick();
    end
    in_de = 1'b0; in_rgb = '0;
  endtask

  task automatic pulse_in_vs();
    in_vs = 1'b1; tick();
    in_vs = 1'b0; tick();
  endtask

  // sx..ey are the window the frame is expected to use; chg >= 0 rewrites start_x mid-frame.
  task automatic run_frame(input int sx, input int sy, input int ex, input int ey,
                           input int base, input int nb, input int ns,
                           input logic lk, input int chg);
    int k;
    logic [23:0] eb, es;
    k = 0;
    cyc(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, lk);
    cyc(1'b1, 1'b0, 1'b0, 24'h0, 24'h0, lk);
    cyc(1'b0, 1'b0, 1'b0, 24'h0, 24'h0, lk);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (chg >= 0 && y == 0 && x == 4) start_x = 11'(chg);
        if (lk && x >= sx && x < ex && y >= sy && y < ey) begin
          eb = (k < nb) ? 24'(base + k) : BG;
          es = (k < ns) ? 24'(base + k) : BG;
          k++;
        end else if (lk && BORDER_EN && ring(x, y, sx, sy, ex, ey)) begin
          eb = BORDER; es = BORDER;
        end else begin
          eb = BG; es = BG;
        end
        cyc(1'b0, 1'b0, 1'b1, eb, es, lk);
      end
      cyc(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, lk);
      cyc(1'b0, 1'b1, 1'b0, 24'h0, 24'h0, lk);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rgb_big", rgb_b, 0);
    chk("rst_rgb_small", rgb_s, 0);
    chk("rst_hs", hs_b, 0);
    chk("rst_vs", vs_b, 0);
    chk("rst_de", de_b, 0);
    chk("rst_locked", locked_b, 0);
    chk("rst_locked_small", locked_s, 0);
    chk("rst_ovf", ovf_s, 0);
    chk("rst_unf", unf_b, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_vs = 1'b0; in_de = 1'b0; in_rgb = '0;
    hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b0;
    start_x = 11'd2; start_y = 11'd1; end_x = 11'd5; end_y = 11'd3;
    bg_rgb = BG;
    #13;
    chk_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();

    // IDLE ignores input pixels.
    pushn(24'h99, 1);
    pulse_in_vs();
    chk("armed_locked", locked_b, 0);
    pushn(1, 6);
    chk("ovf_small_6push", ovf_s, 1);
    chk("ovf_big_6push", ovf_b, 0);

    run_frame(2, 1, 5, 3, 1, 6, 4, 1'b1, -1);
    chk("unf_big_full", unf_b, 0);
    chk("unf_small_short", unf_s, 1);
    chk("locked_small", locked_s, 1);

    pushn(24'h11, 4);
    run_frame(2, 1, 5, 3, 24'h11, 4, 4, 1'b1, -1);
    chk("unf_big_4push", unf_b, 1);
    chk("ovf_big_4push", ovf_b, 0);

    pushn(24'h21, 6);
    run_frame(2, 1, 5, 3, 24'h21, 6, 4, 1'b1, 3);
    pushn(24'h31, 4);
    run_frame(3, 1, 5, 3, 24'h31, 4, 4, 1'b1, -1);

    start_x = 11'd4; end_x = 11'd4;
    pushn(24'h41, 2);
    run_frame(4, 1, 4, 3, 0, 0, 0, 1'b1, -1);
    start_x = 11'd2; end_x = 11'd5;
    run_frame(2, 1, 5, 3, 24'h41, 2, 2, 1'b1, -1);
    chk("ovf_big_end", ovf_b, 0);

    // Reset mid-frame with data pending.
    pushn(24'h51, 4);
    vs_i = 1'b1; tick(); tick();
    vs_i = 1'b0; de_i = 1'b1; tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    de_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_frame(2, 1, 5, 3, 0, 0, 0, 1'b0, -1);
    chk("unf_after_reset_idle", unf_b, 0);
    pulse_in_vs();
    run_frame(2, 1, 5, 3, 0, 0, 0, 1'b1, -1);
    chk("unf_after_reset_run", unf_b, 1);
    chk("ovf_after_reset_run", ovf_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/image_paste.md
Name: image_paste

Overview:
- Inverse of the crop stage: takes a cropped window pixel stream and places it back into a full-resolution output raster at (start_x, start_y).
- Pixels outside the window are filled with a background colour.
- Input window pixels are buffered in an internal FIFO.
- Output raster timing (hs/vs/de) is supplied by the downstream timing generator; the block only sources pixel data against it.

Parameters:
- H_DISP, 12'd1920, active pixels per output line
- V_DISP, 12'd1080, active lines per output frame
- X_RES_WIDTH, 11, width of start_x/end_x
- Y_RES_WIDTH, 11, width of start_y/end_y
- FIFO_AW, 11, FIFO address width; depth = 2^FIFO_AW entries of 24 bits

Ports:
- clk  input  1  pixel clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start_x  input  X_RES_WIDTH  window left column (inclusive)
- start_y  input  Y_RES_WIDTH  window top line (inclusive)
- end_x  input  X_RES_WIDTH  window right column (exclusive)
- end_y  input  Y_RES_WIDTH  window bottom line (exclusive)
- bg_rgb  input  24  fill colour outside the window
- in_vs  input  1  window stream vsync, active high
- in_de  input  1  window stream pixel valid
- in_rgb  input  24  window stream pixel
- hs_i  input  1  output raster hsync
- vs_i  input  1  output raster vsync, active high
- de_i  input  1  output raster data enable
- hs_o  output  1  hs_i delayed 1 cycle
- vs_o  output  1  vs_i delayed 1 cycle
- de_o  output  1  de_i delayed 1 cycle
- rgb_o  output  24  output pixel
- locked  output  1  high in RUN state
- ovf  output  1  sticky: write attempted while FIFO full
- unf  output  1  sticky: in-window read while FIFO empty

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; counters and FIFO pointers = 0.
  - hs_o/vs_o/de_o/locked/ovf/unf = 0; rgb_o = 0.
- States:
  - IDLE -> ARMED on in_vs rising edge. FIFO is cleared in that same cycle.
  - ARMED -> RUN on the first vs_i rising edge.
  - RUN remains until reset.
  - A later in_vs edge does not flush the FIFO.
- Writes:
  - FIFO push when in_de=1 and state != IDLE.
  - Push while full: pixel dropped, ovf set.
- Output raster counters pixel_x/pixel_y (12 bit):
  - Both cleared while vs_i=1.
  - On de_i, pixel_x increments and wraps at H_DISP-1.
  - pixel_y increments on that wrap and wraps at V_DISP-1.
  - Counters stay 0 outside RUN.
- Window registers:
  - start/end values are shadowed into internal registers on each vs_i rising edge; mid-frame changes take effect next frame.
  - win = de_i & RUN & (sx <= pixel_x < ex) & (sy <= pixel_y < ey), using shadow values.
- Reads:
  - FIFO is show-ahead; pop when win=1 and FIFO not empty.
  - win=1 while empty: no pop, pixel = bg_rgb, unf set.
- Output (all outputs registered, latency exactly 1 cycle from hs_i/vs_i/de_i):
  - rgb_o = FIFO head if win & !empty; bg_rgb if de_i & !win or underflow; 0 when de_i=0.
- Degenerate window (ex <= sx or ey <= sy): win never asserts; whole frame is bg_rgb; no reads.
- Simultaneous push and pop: both happen; occupancy unchanged.
- Push and pop while full: allowed; no ovf.
- ovf/unf clear only on reset.

Optional Feature:
- Macro: IMAGE_PASTE_BORDER_EN.
- When defined:
  - Adds parameter BORDER_RGB (default 24'hFF0000).
  - Pixels on the ring exactly one pixel outside the window output BORDER_RGB instead of bg_rgb: x = sx-1 or x = ex with y in [sy-1, ey]; or y = sy-1 or y = ey with x in [sx-1, ex]. Only the parts of the ring that lie inside the raster are drawn.
  - The border consumes no FIFO data.
- When undefined: no border logic; the parameter is absent.

Decomposition:
- Package image_paste_pkg:
  - state enum {IDLE, ARMED, RUN}
  - RGB_W = 24
  - coordinate width constants
- One sub-module, paste_fifo: synchronous single-clock show-ahead FIFO. Parameter FIFO_AW; ports clk, rst_n, clr, push, din, pop, dout, empty, full.

Test Plan:
- Reset mid-frame with FIFO half full -> outputs 0, locked=0, FIFO empty; after reset, no pops until in_vs then vs_i.
- Raster H_DISP=8, V_DISP=4, window (2,1)-(5,3), 6 pixels pushed as 1..6 -> rows 1-2, columns 2-4 output 1..6 in raster order; all other de pixels = bg_rgb; de_o/vs_o/hs_o equal inputs delayed 1 cycle.
- Same raster with only 4 pixels pushed -> last 2 window pixels = bg_rgb, unf=1, ovf=0.
- FIFO_AW=2 and 6 pushes before the window opens -> 4 stored, ovf=1, first 4 window pixels correct.
- start_x changed 2->3 mid-frame -> current frame still uses column 2; the next frame starts at column 3.
- end_x=start_x=4 -> whole frame bg_rgb, FIFO level unchanged. With IMAGE_PASTE_BORDER_EN, window (2,1)-(5,3) -> column 1 and column 5 on rows 0-3, plus row 0 and row 3 on columns 1-5, are BORDER_RGB.
